// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
// Module   : div_iter
// Brief    : Multi-cycle radix-2 restoring divider for the execute stage.
//            One quotient bit per cycle, valid/ready on both sides, flush.
// Revision : 1.0 - initial release
// ============================================================================
module div_iter #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [3:0]      control,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result_out,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [XLEN-1:0]   r_dividend;
  logic [XLEN-1:0]   r_divisor;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_quot;
  logic [6:0]        r_cnt;
  logic              r_w32;
  logic              r_is_rem;
  logic              r_neg_q;
  logic              r_neg_r;
  logic [XLEN-1:0]   r_result;

  // ---------------- opcode decode (used only at acceptance) ----------------
  logic w_w32, w_signed, w_is_rem, w_invalid;
  assign w_invalid = control[3];
  assign w_w32     = (control == 4'd0) || (control == 4'd1) ||
                     (control == 4'd3) || (control == 4'd5);
  assign w_signed  = (control == 4'd0) || (control == 4'd1) ||
                     (control == 4'd6) || (control == 4'd7);
  assign w_is_rem  = (control == 4'd1) || (control == 4'd4) ||
                     (control == 4'd5) || (control == 4'd7);

  // W-bit operands: sign-extended view (for results) and zero-extended view
  // (magnitude of unsigned / non-negative operands).
  logic [XLEN-1:0] w_a_sx, w_b_sx, w_a_zx, w_b_zx, w_a_mag, w_b_mag;
  logic            w_a_neg, w_b_neg;
  assign w_a_sx  = w_w32 ? {{32{src1[31]}}, src1[31:0]} : src1;
  assign w_b_sx  = w_w32 ? {{32{src2[31]}}, src2[31:0]} : src2;
  assign w_a_zx  = w_w32 ? {32'd0, src1[31:0]} : src1;
  assign w_b_zx  = w_w32 ? {32'd0, src2[31:0]} : src2;
  assign w_a_neg = w_signed && (w_w32 ? src1[31] : src1[63]);
  assign w_b_neg = w_signed && (w_w32 ? src2[31] : src2[63]);
  assign w_a_mag = w_a_neg ? (-w_a_sx) : w_a_zx;
  assign w_b_mag = w_b_neg ? (-w_b_sx) : w_b_zx;

  // Special cases resolved in the acceptance cycle.
  logic            w_b_zero, w_ovf, w_special;
  logic [XLEN-1:0] w_special_res;
  assign w_b_zero  = (w_b_zx == '0);
  assign w_ovf     = w_signed && (w_w32 ?
                     ((src1[31:0] == 32'h8000_0000) && (src2[31:0] == 32'hFFFF_FFFF)) :
                     ((src1 == 64'h8000_0000_0000_0000) && (src2 == '1)));
  assign w_special = w_invalid || w_b_zero || w_ovf;

  // Priority: invalid opcode, then divide-by-zero, then signed overflow.
  always_comb begin
    w_special_res = '0;
    if (w_invalid)     w_special_res = '0;
    else if (w_b_zero) w_special_res = w_is_rem ? w_a_sx : '1;
    else if (w_ovf)    w_special_res = w_is_rem ? '0 : w_a_sx;
  end

  logic w_accept, w_last;
  assign w_accept = in_valid && (r_state == S_IDLE) && !flush;
  assign w_last   = (r_state == S_CALC) && (r_cnt == 7'd1);

  // ---------------- restoring step ----------------
  // The partial remainder needs one extra bit after the shift when the
  // divisor has its MSB set.
  logic [XLEN:0]   w_rem_shift;
  logic            w_ge;
  logic [XLEN-1:0] w_rem_nxt, w_quot_nxt;
  assign w_rem_shift = {r_rem, r_dividend[XLEN-1]};
  assign w_ge        = (w_rem_shift >= {1'b0, r_divisor});
  assign w_rem_nxt   = w_ge ? (w_rem_shift[XLEN-1:0] - r_divisor) : w_rem_shift[XLEN-1:0];
  assign w_quot_nxt  = {r_quot[XLEN-2:0], w_ge};

  // Sign fix-up and width extension applied on the final step.
  logic [XLEN-1:0] w_q_fix, w_r_fix, w_raw, w_final;
  assign w_q_fix = r_neg_q ? (-w_quot_nxt) : w_quot_nxt;
  assign w_r_fix = r_neg_r ? (-w_rem_nxt) : w_rem_nxt;
  assign w_raw   = r_is_rem ? w_r_fix : w_q_fix;
  assign w_final = r_w32 ? {{32{w_raw[31]}}, w_raw[31:0]} : w_raw;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; flush overrides every other transition.
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) w_state_nxt = w_special ? S_DONE : S_CALC;
        S_CALC: if (w_last)   w_state_nxt = S_DONE;
        S_DONE: if (out_ready) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath: operand capture at acceptance, one restoring step per CALC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dividend <= '0;
      r_divisor  <= '0;
      r_rem      <= '0;
      r_quot     <= '0;
      r_cnt      <= 7'd0;
      r_w32      <= 1'b0;
      r_is_rem   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_result   <= '0;
    end else if (!flush) begin
      if (w_accept) begin
        // 32-bit operands are left-aligned so the step always consumes bit 63.
        r_dividend <= w_w32 ? {w_a_mag[31:0], 32'd0} : w_a_mag;
        r_divisor  <= w_b_mag;
        r_rem      <= '0;
        r_quot     <= '0;
        r_cnt      <= w_w32 ? 7'd32 : 7'd64;
        r_w32      <= w_w32;
        r_is_rem   <= w_is_rem;
        r_neg_q    <= w_a_neg ^ w_b_neg;
        r_neg_r    <= w_a_neg;
        if (w_special) r_result <= w_special_res;
      end else if (r_state == S_CALC) begin
        r_rem      <= w_rem_nxt;
        r_quot     <= w_quot_nxt;
        r_dividend <= {r_dividend[XLEN-2:0], 1'b0};
        r_cnt      <= r_cnt - 7'd1;
        if (w_last) r_result <= w_final;
      end
    end
  end

  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = (r_state == S_DONE);
  assign busy       = (r_state != S_IDLE);
  assign result_out = r_result;

endmodule
`default_nettype wire

// File: tb/tb_div_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_iter
// Brief    : Scoreboard bench for div_iter with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] src1 = '0;
  logic [63:0] src2 = '0;
  logic [3:0]  control = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] result_out;
  logic        busy;

  div_iter #(.XLEN(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .src1       (src1),
    .src2       (src2),
    .control    (control),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result_out (result_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    int          cyc;
    int          id;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] last_res = '0;
  bit          seen = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Drive one operation; acceptance edge is the posedge right after driving.
  task automatic issue(input int id, input logic [3:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp, input int lat,
                       input bit track);
    exp_t e;
    @(negedge clk);
    check($sformatf("v%0d in_ready_before", id), {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1; control = op; src1 = a; src2 = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0; control = 4'd2;
    src1 = 64'hDEAD_BEEF_0BAD_F00D; src2 = 64'd3;
    if (track) begin
      e.res = exp; e.cyc = cyc + lat; e.id = id;
      sb.push_back(e);
      last_res = exp;
    end
  endtask

  task automatic wait_done(input int id);
    int k;
    k = 0;
    while ((sb.size() != 0 || out_valid) && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) begin
      n_vec++; n_err++;
      $display("FAIL v%0d timeout: got pending=%0d, expected 0", id, sb.size());
    end
  endtask

  // Monitor: pop one expectation per presented result.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && !seen) begin
      seen = 1'b1;
      if (sb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_output: got result %h, expected no output", result_out);
      end else begin
        e = sb.pop_front();
        check($sformatf("v%0d result", e.id), result_out, e.res);
        check($sformatf("v%0d latency_cycle", e.id), 64'(cyc), 64'(e.cyc));
      end
    end
    if (!out_valid) seen = 1'b0;
  end

  initial begin
    int k;
    // Reset values.
    repeat (2) @(negedge clk);
    check("reset in_ready",   {63'd0, in_ready},  64'd1);
    check("reset out_valid",  {63'd0, out_valid}, 64'd0);
    check("reset busy",       {63'd0, busy},      64'd0);
    check("reset result_out", result_out,         64'd0);
    rst_n = 1'b1;

    issue(1,  4'd2, 64'd100, 64'd7, 64'd14, 64, 1'b1); wait_done(1);
    issue(2,  4'd4, 64'd100, 64'd7, 64'd2,  64, 1'b1); wait_done(2);
    issue(3,  4'd1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 32, 1'b1); wait_done(3);
    issue(4,  4'd0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 32, 1'b1); wait_done(4);
    issue(5,  4'd2, 64'd12345, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b1); wait_done(5);
    issue(6,  4'd5, 64'h1_8000_0000, 64'd0, 64'hFFFF_FFFF_8000_0000, 0, 1'b1); wait_done(6);
    issue(7,  4'd0, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 0, 1'b1); wait_done(7);
    issue(8,  4'd7, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0, 1'b1); wait_done(8);
    issue(9,  4'd9, 64'd100, 64'd7, 64'd0, 0, 1'b1); wait_done(9);
    issue(10, 4'd6, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 64, 1'b1); wait_done(10);
    issue(11, 4'd7, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64, 1'b1); wait_done(11);
    issue(12, 4'd3, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 32, 1'b1); wait_done(12);
    issue(13, 4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd1, 64, 1'b1); wait_done(13);
    issue(14, 4'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64, 1'b1); wait_done(14);

    // Backpressure: result and status held while out_ready is low.
    out_ready = 1'b0;
    issue(15, 4'd2, 64'd50, 64'd5, 64'd10, 64, 1'b1);
    k = 0;
    while (!out_valid && k < 100) begin @(negedge clk); k++; end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp result_out", result_out, 64'd10);
      check("bp status {out_valid,in_ready,busy}",
            {61'd0, out_valid, in_ready, busy}, 64'b101);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp release in_ready",  {63'd0, in_ready},  64'd1);
    check("bp release out_valid", {63'd0, out_valid}, 64'd0);
    wait_done(15);

    // Flush at CALC cycle 20: no output, result_out untouched.
    issue(16, 4'd2, 64'd1000, 64'd7, 64'd0, 64, 1'b0);
    repeat (19) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    check("flush in_ready",   {63'd0, in_ready},  64'd1);
    check("flush out_valid",  {63'd0, out_valid}, 64'd0);
    check("flush result_out", result_out, last_res);
    repeat (80) @(negedge clk);
    issue(17, 4'd2, 64'd9, 64'd3, 64'd3, 64, 1'b1); wait_done(17);

    // Asynchronous reset at CALC cycle 20.
    issue(18, 4'd2, 64'd1000, 64'd7, 64'd0, 64, 1'b0);
    repeat (19) @(posedge clk);
    @(negedge clk); #2; rst_n = 1'b0;
    #1;
    check("areset in_ready",   {63'd0, in_ready},  64'd1);
    check("areset out_valid",  {63'd0, out_valid}, 64'd0);
    check("areset busy",       {63'd0, busy},      64'd0);
    check("areset result_out", result_out,         64'd0);
    @(negedge clk); rst_n = 1'b1;
    last_res = '0;
    repeat (80) @(negedge clk);
    issue(19, 4'd2, 64'd9, 64'd3, 64'd3, 64, 1'b1); wait_done(19);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog.
  initial begin
    #400000;
    $display("FAIL watchdog: got no completion, expected $finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
